// File: rtl/conv_l2_mac.sv
// Layer-2 3x3xICH convolution MAC: one window in, OCH ReLU/shift/saturated pixels out.
// Optional macro CONV_L2_BIAS_EN adds per-output-channel bias registers.
module conv_l2_mac #(
    parameter int ICH   = 16,
    parameter int OCH   = 32,
    parameter int B     = 8,
    parameter int kx    = 3,
    parameter int ky    = 3,
    parameter int ACCW  = 32,
    parameter int SHIFT = 7
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [ICH*kx*ky*B-1:0]         i_pixel_data,
    input  logic [ICH-1:0]                 i_pixel_data_valid,
    output logic                           o_ready,
    input  logic                           i_wr_en,
    input  logic [$clog2(OCH)-1:0]         i_wr_oc,
    input  logic [$clog2(ICH*kx*ky+1)-1:0] i_wr_idx,
    input  logic [B-1:0]                   i_wr_data,
    output logic [B-1:0]                   o_data,
    output logic                           o_valid,
    output logic [$clog2(OCH)-1:0]         o_ch,
    output logic                           o_last,
    output logic                           o_wr_err
);
    localparam int NW   = ICH * kx * ky;
    localparam int OCW  = $clog2(OCH);
    localparam int IDXW = $clog2(NW + 1);
    localparam int PW   = 2 * B + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [OCW-1:0]      k_q, k_d;
    logic                accept;

    logic signed [B-1:0] w_q [OCH][NW];
    logic [NW*B-1:0]     win_q;
    logic signed [PW-1:0] prod_q [NW];
    logic                v1_q;
    logic [OCW-1:0]      ch1_q;

    logic                pend_v_q;
    logic [OCW-1:0]      pend_oc_q;
    logic [IDXW-1:0]     pend_idx_q;
    logic [B-1:0]        pend_data_q;
    logic                pend_apply;

    logic                we;
    logic [OCW-1:0]      woc;
    logic [IDXW-1:0]     widx;
    logic [B-1:0]        wdat;

    logic signed [ACCW-1:0] acc;
    logic [ACCW-1:0]     shr;
    logic [B-1:0]        sat;

    logic [B-1:0]        o_data_q;
    logic                o_valid_q, o_last_q, o_wr_err_q;
    logic [OCW-1:0]      o_ch_q;

`ifdef CONV_L2_BIAS_EN
    logic signed [B-1:0] bias_q [OCH];
    logic signed [B-1:0] bias1_q;
`endif

    assign accept   = (state_q == IDLE) && (&i_pixel_data_valid);
    assign o_ready  = (state_q == IDLE);
    assign o_data   = o_data_q;
    assign o_valid  = o_valid_q;
    assign o_ch     = o_ch_q;
    assign o_last   = o_last_q;
    assign o_wr_err = o_wr_err_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE:  if (accept) begin
                       state_d = RUN;
                       k_d     = '0;
                   end
            RUN:   if (k_q == OCW'(OCH - 1)) begin
                       state_d = DRAIN;
                       k_d     = '0;
                   end else begin
                       k_d = k_q + OCW'(1);
                   end
            DRAIN: if (o_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A write coinciding with an accept is parked and committed when the engine
    // returns to IDLE, so the window just accepted still sees the old coefficient.
    assign pend_apply = pend_v_q && (state_q == DRAIN) && (state_d == IDLE);

    always_comb begin
        we   = 1'b0;
        woc  = i_wr_oc;
        widx = i_wr_idx;
        wdat = i_wr_data;
        if ((state_q == IDLE) && i_wr_en && !accept) begin
            we = 1'b1;
        end else if (pend_apply) begin
            we   = 1'b1;
            woc  = pend_oc_q;
            widx = pend_idx_q;
            wdat = pend_data_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (we && (widx < IDXW'(NW))) w_q[woc][widx] <= wdat;
`ifdef CONV_L2_BIAS_EN
        if (we && (widx == IDXW'(NW))) bias_q[woc] <= wdat;
`endif
        if (accept) win_q <= i_pixel_data;
        if (state_q == RUN) begin
            for (int unsigned i = 0; i < NW; i++)
                prod_q[i] <= $signed({1'b0, win_q[i*B +: B]}) * w_q[k_q][i];
`ifdef CONV_L2_BIAS_EN
            bias1_q <= bias_q[k_q];
`endif
        end
    end

    always_comb begin
`ifdef CONV_L2_BIAS_EN
        acc = {{(ACCW-B){bias1_q[B-1]}}, bias1_q};
`else
        acc = '0;
`endif
        for (int unsigned i = 0; i < NW; i++)
            acc = acc + {{(ACCW-PW){prod_q[i][PW-1]}}, prod_q[i]};
        shr = acc[ACCW-1] ? '0 : ACCW'(acc >>> SHIFT);
        sat = (|shr[ACCW-1:B]) ? '1 : shr[B-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            v1_q        <= 1'b0;
            ch1_q       <= '0;
            pend_v_q    <= 1'b0;
            pend_oc_q   <= '0;
            pend_idx_q  <= '0;
            pend_data_q <= '0;
            o_data_q    <= '0;
            o_valid_q   <= 1'b0;
            o_ch_q      <= '0;
            o_last_q    <= 1'b0;
            o_wr_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            v1_q    <= (state_q == RUN);
            ch1_q   <= k_q;
            if (accept && i_wr_en) begin
                pend_v_q    <= 1'b1;
                pend_oc_q   <= i_wr_oc;
                pend_idx_q  <= i_wr_idx;
                pend_data_q <= i_wr_data;
            end else if (pend_apply) begin
                pend_v_q <= 1'b0;
            end
            if (i_wr_en && (state_q != IDLE)) o_wr_err_q <= 1'b1;
            o_valid_q <= v1_q;
            o_last_q  <= v1_q && (ch1_q == OCW'(OCH - 1));
            if (v1_q) begin
                o_data_q <= sat;
                o_ch_q   <= ch1_q;
            end
        end
    end
endmodule

// File: tb/tb_conv_l2_mac.sv
// Directed self-checking bench for conv_l2_mac (default parameters).
module tb_conv_l2_mac;
    localparam int ICH = 16, OCH = 32, B = 8, NW = 144, OCW = 5, IDXW = 8, NJ = 35;

    logic              i_clk, i_rst;
    logic [NW*B-1:0]   i_pixel_data;
    logic [ICH-1:0]    i_pixel_data_valid;
    logic              o_ready;
    logic              i_wr_en;
    logic [OCW-1:0]    i_wr_oc;
    logic [IDXW-1:0]   i_wr_idx;
    logic [B-1:0]      i_wr_data;
    logic [B-1:0]      o_data;
    logic              o_valid;
    logic [OCW-1:0]    o_ch;
    logic              o_last;
    logic              o_wr_err;

    int n_vec = 0;
    int n_fail = 0;

    logic            r_vld [NJ];
    logic            r_last[NJ];
    logic            r_rdy [NJ];
    logic [OCW-1:0]  r_ch  [NJ];
    logic [B-1:0]    r_data[NJ];
    logic [B-1:0]    exp_d [OCH];

    conv_l2_mac #(.ICH(16), .OCH(32), .B(8), .kx(3), .ky(3), .ACCW(32), .SHIFT(7)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_pixel_data(i_pixel_data), .i_pixel_data_valid(i_pixel_data_valid),
        .o_ready(o_ready),
        .i_wr_en(i_wr_en), .i_wr_oc(i_wr_oc), .i_wr_idx(i_wr_idx), .i_wr_data(i_wr_data),
        .o_data(o_data), .o_valid(o_valid), .o_ch(o_ch), .o_last(o_last), .o_wr_err(o_wr_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic wr(input int oc, input int idx, input int d);
        i_wr_en   = 1'b1;
        i_wr_oc   = OCW'(oc);
        i_wr_idx  = IDXW'(idx);
        i_wr_data = B'(d);
        @(negedge i_clk);
        i_wr_en = 1'b0;
    endtask

    task automatic fill(input int w, input int b);
        for (int oc = 0; oc < OCH; oc++) begin
            for (int idx = 0; idx < NW; idx++) wr(oc, idx, w);
            wr(oc, NW, b);
        end
    endtask

    task automatic set_pix(input int p);
        i_pixel_data = '0;
        for (int i = 0; i < NW; i++) i_pixel_data[i*B +: B] = B'(p);
    endtask

    // Accepts one window and records outputs for cycles T+1..T+35 (index j = cycle-T-1).
    task automatic run_window(input bit acc_wr, input int wr_j, input int oc, input int idx, input int d);
        i_pixel_data_valid = '1;
        if (acc_wr) begin
            i_wr_en = 1'b1; i_wr_oc = OCW'(oc); i_wr_idx = IDXW'(idx); i_wr_data = B'(d);
        end
        @(negedge i_clk);
        i_pixel_data_valid = '0;
        i_wr_en = 1'b0;
        for (int j = 0; j < NJ; j++) begin
            r_vld[j] = o_valid; r_last[j] = o_last; r_rdy[j] = o_ready;
            r_ch[j] = o_ch; r_data[j] = o_data;
            i_wr_en = 1'b0;
            if (j == wr_j) begin
                i_wr_en = 1'b1; i_wr_oc = OCW'(oc); i_wr_idx = IDXW'(idx); i_wr_data = B'(d);
            end
            if (j < NJ - 1) @(negedge i_clk);
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        n_vec++;
        if ({o_ready, o_valid, o_data, o_ch, o_last, o_wr_err} !== {1'b1, 1'b0, 8'd0, 5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b data=%0d ch=%0d last=%b err=%b, want 1 0 0 0 0 0",
                     o_ready, o_valid, o_data, o_ch, o_last, o_wr_err);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_ones;
        fill(1, 0);
        set_pix(1);
        run_window(1'b0, -1, 0, 0, 0);
        for (int j = 0; j < NJ; j++) begin
            bit ev = (j >= 2) && (j <= 33);
            n_vec++;
            if (r_vld[j] !== ev || r_last[j] !== (j == 33) || r_rdy[j] !== (j >= 34)) begin
                n_fail++;
                $display("FAIL ones_timing j=%0d: got vld=%b last=%b rdy=%b, want %b %b %b",
                         j, r_vld[j], r_last[j], r_rdy[j], ev, (j == 33), (j >= 34));
            end
            if (ev) begin
                n_vec++;
                if (r_ch[j] !== OCW'(j - 2) || r_data[j] !== 8'd1) begin
                    n_fail++;
                    $display("FAIL ones_data j=%0d: got ch=%0d data=%0d, want ch=%0d data=1",
                             j, r_ch[j], r_data[j], j - 2);
                end
            end
        end
    endtask

    task automatic test_single_weight;
        fill(0, 0);
        wr(5, 4, 127);
        set_pix(0);
        i_pixel_data[4*B +: B] = 8'd255;
        run_window(1'b0, -1, 0, 0, 0);
        for (int k = 0; k < OCH; k++) exp_d[k] = (k == 5) ? 8'd253 : 8'd0;
        for (int k = 0; k < OCH; k++) begin
            n_vec++;
            if (r_data[k+2] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL single_weight ch=%0d: got %0d want %0d", k, r_data[k+2], exp_d[k]);
            end
        end
    endtask

    task automatic test_relu_sat;
        fill(-1, 0);
        set_pix(200);
        run_window(1'b0, -1, 0, 0, 0);
        for (int k = 0; k < OCH; k++) begin
            n_vec++;
            if (r_data[k+2] !== 8'd0) begin
                n_fail++;
                $display("FAIL relu ch=%0d: got %0d want 0", k, r_data[k+2]);
            end
        end
        fill(127, 0);
        set_pix(255);
        run_window(1'b0, -1, 0, 0, 0);
        for (int k = 0; k < OCH; k++) begin
            n_vec++;
            if (r_data[k+2] !== 8'd255) begin
                n_fail++;
                $display("FAIL saturate ch=%0d: got %0d want 255", k, r_data[k+2]);
            end
        end
    endtask

    task automatic test_bias;
        fill(0, 0);
        wr(3, NW, 100);
        wr(3, 200, 127);
        set_pix(0);
        run_window(1'b0, -1, 0, 0, 0);
        for (int k = 0; k < OCH; k++) begin
            n_vec++;
            if (r_data[k+2] !== 8'd0) begin
                n_fail++;
                $display("FAIL bias100 ch=%0d: got %0d want 0", k, r_data[k+2]);
            end
        end
        for (int oc = 0; oc < OCH; oc++) wr(oc, NW, 127);
        wr(3, 0, 1);
        i_pixel_data[0 +: B] = 8'd255;
        run_window(1'b0, -1, 0, 0, 0);
`ifdef CONV_L2_BIAS_EN
        for (int k = 0; k < OCH; k++) exp_d[k] = (k == 3) ? 8'd2 : 8'd0;
`else
        for (int k = 0; k < OCH; k++) exp_d[k] = (k == 3) ? 8'd1 : 8'd0;
`endif
        for (int k = 0; k < OCH; k++) begin
            n_vec++;
            if (r_data[k+2] !== exp_d[k]) begin
                n_fail++;
                $display("FAIL bias127 ch=%0d: got %0d want %0d", k, r_data[k+2], exp_d[k]);
            end
        end
        n_vec++;
        if (o_wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_wr_err: got %b want 0", o_wr_err);
        end
    endtask

    task automatic test_partial;
        i_pixel_data_valid = 16'h7FFF;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            n_vec++;
            if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL partial c=%0d: got rdy=%b vld=%b want 1 0", c, o_ready, o_valid);
            end
        end
        i_pixel_data_valid = '0;
        @(negedge i_clk);
    endtask

    task automatic test_back_to_back;
        fill(0, 0);
        wr(0, 0, 127);
        set_pix(0);
        i_pixel_data[0 +: B] = 8'd255;
        run_window(1'b0, 5, 0, 0, 100);
        n_vec++;
        if (r_data[2] !== 8'd253 || o_wr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL run_write: got ch0=%0d err=%b want 253 1", r_data[2], o_wr_err);
        end
        run_window(1'b1, -1, 0, 0, 0);
        n_vec++;
        if (r_data[2] !== 8'd253) begin
            n_fail++;
            $display("FAIL accept_write_old: got ch0=%0d want 253", r_data[2]);
        end
        run_window(1'b0, -1, 0, 0, 0);
        for (int k = 0; k < OCH; k++) begin
            n_vec++;
            if (r_data[k+2] !== 8'd0) begin
                n_fail++;
                $display("FAIL accept_write_new ch=%0d: got %0d want 0", k, r_data[k+2]);
            end
        end
    endtask

    task automatic test_reset_midrun;
        int nv;
        wr(7, 0, 1);
        i_pixel_data_valid = '1;
        @(negedge i_clk);
        i_pixel_data_valid = '0;
        repeat (9) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        n_vec++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: got vld=%b rdy=%b err=%b want 0 1 0", o_valid, o_ready, o_wr_err);
        end
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got vld=%b want 0", o_valid);
        end
        run_window(1'b0, -1, 0, 0, 0);
        nv = 0;
        for (int j = 0; j < NJ; j++) nv += int'(r_vld[j]);
        n_vec++;
        if (nv !== 32 || r_last[33] !== 1'b1 || r_ch[33] !== 5'd31) begin
            n_fail++;
            $display("FAIL restart_seq: got valids=%0d last=%b ch=%0d want 32 1 31", nv, r_last[33], r_ch[33]);
        end
        for (int k = 0; k < OCH; k++) begin
            n_vec++;
            if (r_data[k+2] !== ((k == 7) ? 8'd1 : 8'd0)) begin
                n_fail++;
                $display("FAIL restart_data ch=%0d: got %0d want %0d", k, r_data[k+2], (k == 7) ? 1 : 0);
            end
        end
    endtask

    initial begin
        i_rst = 1'b0;
        i_pixel_data = '0;
        i_pixel_data_valid = '0;
        i_wr_en = 1'b0;
        i_wr_oc = '0;
        i_wr_idx = '0;
        i_wr_data = '0;
        test_reset;
        test_ones;
        test_single_weight;
        test_relu_sat;
        test_bias;
        test_partial;
        test_back_to_back;
        test_reset_midrun;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
